// File: rtl/bank_ctrl_pkg.sv
// Shared definitions for the bank write controller: FSM state encoding,
// bank geometry and the strobe counter width.
package bank_ctrl_pkg;

    localparam int NUM_ENTRIES = 4;
    localparam int ADDR_W      = 2;
    // Wide enough to count up to the largest legal STROBE_CYCLES (15).
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // One-hot enable for a bank entry address.
    function automatic logic [NUM_ENTRIES-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        return NUM_ENTRIES'(1) << addr;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the requester that
// wins a tie; it moves to the other requester only when a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       sel_o
);

    logic ptr_q;
    logic ptr_d;

    // Selection: a lone requester wins; on a tie or no request, follow the pointer.
    always_comb begin
        sel_o = ptr_q;
        case (req_i)
            2'b01:   sel_o = 1'b0;
            2'b10:   sel_o = 1'b1;
            default: sel_o = ptr_q;
        endcase
    end

    // Pointer next state: hand priority to the requester not just served.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = ~sel_o;
        end
    end

    // Pointer register; requester 0 has priority out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bank_ctrl.sv
// Bank write controller: arbitrates two write requesters and sequences each
// write as SETUP -> STROBE (STROBE_CYCLES long) -> HOLD towards four
// level-sensitive bank latches.
// Optional feature macro: BANK_CTRL_SHADOW_EN adds a readable shadow copy
// of the four bank entries.
//
// Handshake: a requester's write is taken at a rising clock edge where its
// valid and ready are both high; ready is only offered in IDLE to the
// requester the arbiter currently selects, and captured address/data are
// held internally until the controller returns to IDLE.
module bank_ctrl
    import bank_ctrl_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [1:0]        req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [1:0]        req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [3:0]        wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        dbg_state_o
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic [NUM_ENTRIES-1:0]  wr_en_q, wr_en_d;
    logic                    busy_q, busy_d;
    logic                    sel;
    logic                    accept;
    logic                    last_strobe;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({req1_valid, req0_valid}),
        .accept_i (accept),
        .sel_o    (sel)
    );

    assign accept      = (state_q == IDLE) && (sel ? req1_valid : req0_valid);
    assign last_strobe = (state_q == STROBE) && (cnt_q == CNT_W'(STROBE_CYCLES - 1));

    // Ready is decoded combinationally so a requester sees it in the same cycle.
    assign req0_ready = (state_q == IDLE) && !sel;
    assign req1_ready = (state_q == IDLE) && sel;

    // Next state, capture and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SETUP;
                    addr_d    = sel ? req1_addr : req0_addr;
                    wr_data_d = sel ? req1_data : req0_data;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = '0;
            end
            STROBE: begin
                if (last_strobe) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered, so decode them from the next state.
        wr_en_d = (state_d == STROBE) ? addr_onehot(addr_d) : '0;
        busy_d  = (state_d != IDLE);
    end

    // State, capture and output registers; reset aborts any write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

`ifdef BANK_CTRL_SHADOW_EN
    logic [DATA_W-1:0] shadow_q [NUM_ENTRIES];
    logic [DATA_W-1:0] rd_data_q;

    // Shadow copy updated as the strobe completes; readback is one cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                shadow_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (last_strobe) begin
                shadow_q[addr_q] <= wr_data_q;
            end
            rd_data_q <= shadow_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_bank_ctrl.sv
// Bench for bank_ctrl: a timeline-based reference model of the default
// (STROBE_CYCLES=2) instance plus two extra instances for the 1 and 15 cycle
// strobe widths. Shadow expectations follow BANK_CTRL_SHADOW_EN.
module tb_bank_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0v, r1v;
    logic [1:0] r0a, r1a;
    logic [7:0] r0d, r1d;
    logic [1:0] rd_addr;

    logic       rdy0, rdy1, busy;
    logic [3:0] wr_en;
    logic [7:0] wr_data, rd_data;
    logic [1:0] st;

    logic       rdy0_1, rdy1_1, busy_1;
    logic [3:0] wr_en_1;
    logic [7:0] wr_data_1, rd_data_1;
    logic [1:0] st_1;

    logic       rdy0_15, rdy1_15, busy_15;
    logic [3:0] wr_en_15;
    logic [7:0] wr_data_15, rd_data_15;
    logic [1:0] st_15;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bank_ctrl #(.DATA_W(8), .STROBE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(rdy0),
        .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(rdy1),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state_o(st)
    );

    bank_ctrl #(.DATA_W(8), .STROBE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(rdy0_1),
        .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(rdy1_1),
        .wr_en(wr_en_1), .wr_data(wr_data_1), .busy(busy_1),
        .rd_addr(rd_addr), .rd_data(rd_data_1), .dbg_state_o(st_1)
    );

    bank_ctrl #(.DATA_W(8), .STROBE_CYCLES(15)) dut_s15 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(rdy0_15),
        .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(rdy1_15),
        .wr_en(wr_en_15), .wr_data(wr_data_15), .busy(busy_15),
        .rd_addr(rd_addr), .rd_data(rd_data_15), .dbg_state_o(st_15)
    );

    // Reference model: each accepted write occupies a fixed timeline of
    // 3+S cycles; k counts cycles since the accepting edge.
    bit         m_active;
    int         m_k;
    int         m_prio;
    int         m_g;
    logic [1:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_shadow [4];
    logic [7:0] m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_k      = 0;
            m_prio   = 0;
            m_addr   = 2'd0;
            m_wdata  = 8'h00;
            m_rd     = 8'h00;
            for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
        end else begin
            m_rd = m_shadow[rd_addr];
            if (!m_active) begin
                if (r0v || r1v) begin
                    if (r0v && r1v) m_g = m_prio;
                    else            m_g = r1v ? 1 : 0;
                    m_active = 1'b1;
                    m_k      = 1;
                    m_addr   = (m_g == 1) ? r1a : r0a;
                    m_wdata  = (m_g == 1) ? r1d : r0d;
                    m_prio   = 1 - m_g;
                end
            end else begin
                m_k++;
                if (m_k == 2 + S) m_shadow[m_addr] = m_wdata;
                if (m_k == 3 + S) m_active = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        r0v = 1'b0; r1v = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r0v = 1'b0; r1v = 1'b0;
        r0a = 2'd0; r1a = 2'd0; r0d = 8'h00; r1d = 8'h00; rd_addr = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL reset_wr_en got=%b exp=0000", wr_en); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if ({rdy1, rdy0} !== 2'b01) begin errors++; $display("FAIL reset_ready got=%b exp=01", {rdy1, rdy0}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        logic [3:0] exp_en;
        @(negedge clk);
        r0v = 1'b1; r0a = 2'd2; r0d = 8'hA5; r1v = 1'b0;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", rdy0); end
        @(posedge clk);
        #1;
        r0v = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            exp_en = (c >= 2 && c <= 1 + S) ? 4'b0100 : 4'b0000;
            checks++; if (wr_en !== exp_en) begin errors++; $display("FAIL single_wr_en cyc=%0d got=%b exp=%b", c, wr_en, exp_en); end
            checks++; if (wr_data !== 8'hA5) begin errors++; $display("FAIL single_wr_data cyc=%0d got=%h exp=a5", c, wr_data); end
            checks++; if (busy !== (c <= 2 + S)) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy, (c <= 2 + S)); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_contention();
        int grants[4];
        int gcyc[4];
        int n = 0;
        do_reset();
        r0v = 1'b1; r0a = 2'd0; r0d = 8'h11;
        r1v = 1'b1; r1a = 2'd3; r1d = 8'h22;
        #1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            checks++; if (rdy0 && rdy1) begin errors++; $display("FAIL cont_both_ready cyc=%0d got=11 exp=not11", i); end
            if (rdy0 || rdy1) begin
                grants[n] = rdy1 ? 1 : 0;
                gcyc[n]   = i;
                n++;
            end
            @(posedge clk);
            #1;
        end
        r0v = 1'b0; r1v = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL cont_grant_count got=%0d exp=4", n); end
        for (int j = 0; j < n; j++) begin
            checks++; if (grants[j] != (j % 2)) begin errors++; $display("FAIL cont_grant_order idx=%0d got=%0d exp=%0d", j, grants[j], j % 2); end
        end
        for (int j = 1; j < n; j++) begin
            checks++; if (gcyc[j] - gcyc[j-1] != 3 + S) begin errors++; $display("FAIL cont_spacing idx=%0d got=%0d exp=%0d", j, gcyc[j] - gcyc[j-1], 3 + S); end
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_random();
        logic [3:0] exp_en;
        logic [7:0] exp_rd;
        int         exp_sel;
        do_reset();
        #1;
        for (int i = 0; i < 400; i++) begin
            exp_en = (m_active && m_k >= 2 && m_k <= 1 + S) ? (4'b0001 << m_addr) : 4'b0000;
`ifdef BANK_CTRL_SHADOW_EN
            exp_rd = m_rd;
`else
            exp_rd = 8'h00;
`endif
            if (r0v && r1v)   exp_sel = m_prio;
            else if (r1v)     exp_sel = 1;
            else if (r0v)     exp_sel = 0;
            else              exp_sel = m_prio;
            checks++; if (wr_en !== exp_en) begin errors++; $display("FAIL rand_wr_en cyc=%0d got=%b exp=%b", i, wr_en, exp_en); end
            checks++; if (wr_data !== m_wdata) begin errors++; $display("FAIL rand_wr_data cyc=%0d got=%h exp=%h", i, wr_data, m_wdata); end
            checks++; if (busy !== m_active) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, busy, m_active); end
            checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rand_rd_data cyc=%0d got=%h exp=%h", i, rd_data, exp_rd); end
            checks++; if (rdy0 !== (!m_active && exp_sel == 0)) begin errors++; $display("FAIL rand_ready0 cyc=%0d got=%b exp=%b", i, rdy0, (!m_active && exp_sel == 0)); end
            checks++; if (rdy1 !== (!m_active && exp_sel == 1)) begin errors++; $display("FAIL rand_ready1 cyc=%0d got=%b exp=%b", i, rdy1, (!m_active && exp_sel == 1)); end
            r0v = ($urandom_range(0, 2) != 0);
            r1v = ($urandom_range(0, 2) != 0);
            r0a = 2'($urandom_range(0, 3));
            r1a = 2'($urandom_range(0, 3));
            r0d = 8'($urandom_range(0, 255));
            r1d = 8'($urandom_range(0, 255));
            rd_addr = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        r0v = 1'b0; r1v = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset_mid_strobe();
        bit found = 1'b0;
        do_reset();
        r0v = 1'b1; r0a = 2'd1; r0d = 8'h5A; r1v = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            if (wr_en == 4'b0010) found = 1'b1;
        end
        r0v = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL mid_strobe_reached got=0 exp=1"); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wr_en !== 4'b0000) begin errors++; $display("FAIL mid_strobe_wr_en got=%b exp=0000", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_strobe_busy got=%b exp=0", busy); end
        @(negedge clk);
        r0v = 1'b1; r0a = 2'd0; r0d = 8'hC3;
        r1v = 1'b1; r1a = 2'd2; r1d = 8'h3C;
        rst_n = 1'b1;
        #1;
        checks++; if ({rdy1, rdy0} !== 2'b01) begin errors++; $display("FAIL post_reset_grant got=%b exp=01", {rdy1, rdy0}); end
        @(posedge clk);
        #1;
        r0v = 1'b0; r1v = 1'b0;
        checks++; if (wr_data !== 8'hC3) begin errors++; $display("FAIL post_reset_data got=%h exp=c3", wr_data); end
        repeat (8) @(posedge clk);
    endtask

    task automatic test_strobe_widths();
        int acc1[2], acc15[2];
        int n1 = 0, n15 = 0, hi1 = 0, hi15 = 0, bad = 0;
        do_reset();
        r0v = 1'b1; r0a = 2'd3; r0d = 8'h77; r1v = 1'b0;
        #1;
        for (int i = 0; i < 60; i++) begin
            if (wr_en_1 != 4'b0000 && n1 == 1) hi1++;
            if (wr_en_15 != 4'b0000 && n15 == 1) hi15++;
            if (wr_en_1 != 4'b0000 && wr_en_1 != 4'b1000) bad++;
            if (wr_en_15 != 4'b0000 && wr_en_15 != 4'b1000) bad++;
            if (rdy0_1) begin if (n1 < 2) acc1[n1] = i; n1++; end
            if (rdy0_15) begin if (n15 < 2) acc15[n15] = i; n15++; end
            @(posedge clk);
            #1;
        end
        r0v = 1'b0;
        checks++; if (hi1 != 1) begin errors++; $display("FAIL s1_width got=%0d exp=1", hi1); end
        checks++; if (hi15 != 15) begin errors++; $display("FAIL s15_width got=%0d exp=15", hi15); end
        checks++; if (bad != 0) begin errors++; $display("FAIL strobe_onehot got=%0d exp=0", bad); end
        checks++; if (n1 < 2 || acc1[1] - acc1[0] != 4) begin errors++; $display("FAIL s1_spacing got=%0d exp=4", (n1 < 2) ? -1 : acc1[1] - acc1[0]); end
        checks++; if (n15 < 2 || acc15[1] - acc15[0] != 18) begin errors++; $display("FAIL s15_spacing got=%0d exp=18", (n15 < 2) ? -1 : acc15[1] - acc15[0]); end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_shadow();
        logic [7:0] exp_rd;
        bit seen_busy = 1'b0;
        bit done = 1'b0;
`ifdef BANK_CTRL_SHADOW_EN
        exp_rd = 8'h3C;
`else
        exp_rd = 8'h00;
`endif
        do_reset();
        rd_addr = 2'd1;
        r0v = 1'b1; r0a = 2'd1; r0d = 8'h3C; r1v = 1'b0;
        @(posedge clk);
        #1;
        r0v = 1'b0;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL shadow_before got=%h exp=00", rd_data); end
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) done = 1'b1;
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL shadow_write_done got=0 exp=1"); end
        checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL shadow_readback got=%h exp=%h", rd_data, exp_rd); end
        rd_addr = 2'd2;
        @(posedge clk);
        #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL shadow_other_entry got=%h exp=00", rd_data); end
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_random();
        test_reset_mid_strobe();
        test_strobe_widths();
        test_shadow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_ctrl.md
BANK_CTRL -- requirements
Module: bank_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of each bank entry and of all data ports.
REQ-002 Parameter STROBE_CYCLES, default 2: cycles wr_en stays high per write; legal range 1..15.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid  input  1  requester 0 has a write pending.
REQ-006 req0_addr  input  2  requester 0 target entry 0..3.
REQ-007 req0_data  input  DATA_W  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 accepted when valid and ready both high at a clock edge.
REQ-009 req1_valid / req1_addr / req1_data / req1_ready: same as REQ-005..008 for requester 1.
REQ-010 wr_en  output  4  one-hot level enable to the four bank latches.
REQ-011 wr_data  output  DATA_W  data driven to all bank latches.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 rd_addr  input  2  shadow readback select.
REQ-014 rd_data  output  DATA_W  shadow readback value.

Function
REQ-015 FSM states IDLE, SETUP, STROBE, HOLD; transitions IDLE->SETUP on accept, SETUP->STROBE after 1 cycle, STROBE->HOLD after STROBE_CYCLES cycles, HOLD->IDLE after 1 cycle.
REQ-016 reqN_ready is high only in IDLE and only for the requester the arbiter selects; both readies never high together.
REQ-017 Arbiter: one valid -> that requester; both valid -> requester not served last; neither valid -> selection follows the pointer, no accept.
REQ-018 Round-robin pointer updates only on accept.
REQ-019 On accept, addr and data are captured into internal registers; requester inputs are ignored until return to IDLE.
REQ-020 wr_data equals the captured data from SETUP through HOLD inclusive and holds its last value in IDLE.
REQ-021 wr_en is one-hot of the captured addr during STROBE only; all-zero in IDLE, SETUP, HOLD.
REQ-022 Accept at edge T: SETUP in cycle T+1, wr_en high cycles T+2..T+1+STROBE_CYCLES, HOLD at T+2+STROBE_CYCLES, next accept possible at edge T+3+STROBE_CYCLES.
REQ-023 Back-to-back writes to the same address are sequenced identically; no merging or skipping.
REQ-024 All outputs are registered except reqN_ready, which is decoded from state and arbiter selection.

Reset
REQ-025 rst_n low forces state IDLE, wr_en 0, wr_data 0, busy 0, pointer to requester 0, shadow entries 0, immediately and independently of clk.
REQ-026 Reset during SETUP, STROBE or HOLD aborts the write; wr_en drops asynchronously and the in-flight request is lost, not retried.
REQ-027 First accept after reset release with both valid goes to requester 0.

Configuration
REQ-028 Macro BANK_CTRL_SHADOW_EN defined: four DATA_W shadow registers, each updated with wr_data on the last STROBE cycle of a write to that entry; rd_data = shadow[rd_addr], registered, 1-cycle latency.
REQ-029 Macro undefined: no shadow storage, rd_addr ignored, rd_data constant 0.

Structure
REQ-030 Package bank_ctrl_pkg holds the state enum, NUM_ENTRIES=4, ADDR_W=2, and the STROBE_CYCLES counter width.
REQ-031 Sub-module rr_arb2 (two-requester round-robin, selection and pointer) is instantiated once; the FSM, capture and shadow logic stay in bank_ctrl.

Verification
REQ-032 Single write: req0 addr=2 data=0xA5 -> ready accepted, wr_en=4'b0100 for exactly 2 cycles starting 2 cycles after accept, wr_data=0xA5 SETUP..HOLD.
REQ-033 Contention: both valid continuously, req0 addr=0 data=0x11, req1 addr=3 data=0x22 -> grants alternate 0,1,0,1, one accept every 5 cycles.
REQ-034 Reset mid-STROBE: assert rst_n low during a write to entry 1 -> wr_en=0 same cycle, busy=0, after release both valid grants req0.
REQ-035 STROBE_CYCLES=1 and 15: wr_en width 1 and 15 cycles; accept spacing 4 and 18 cycles.
REQ-036 With BANK_CTRL_SHADOW_EN: write 0x3C to entry 1, rd_addr=1 -> rd_data=0x3C one cycle after HOLD; without macro rd_data stays 0.
